// File: rtl/mux_n_1_pipelined.sv
// N:1 mux tree (N = 2**SEL_W) with a register stage every REG_EVERY levels
// and a valid/ready handshake; all stages advance together on en.
module mux_n_1_pipelined #(
  parameter int W         = 4,
  parameter int SEL_W     = 3,
  parameter int REG_EVERY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [(2**SEL_W)*W-1:0]    data,
  input  logic [SEL_W-1:0]           sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic [SEL_W-1:0]           out_sel
);

  localparam int N      = 2**SEL_W;
  localparam int STAGES = (SEL_W + REG_EVERY - 1) / REG_EVERY;

  logic en;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en & rst_n;

  for (genvar l = 0; l < SEL_W; l++) begin : g_lvl
    localparam int S  = l / REG_EVERY;
    localparam int WI = (N >> l) * W;
    localparam int WO = (N >> (l + 1)) * W;

    logic [WI-1:0] x;
    logic [WO-1:0] y;
    logic          b;

    if (l == 0) begin : g_src_in
      assign x = data;
    end else if (l % REG_EVERY == 0) begin : g_src_reg
      assign x = g_stg[S-1].d;
    end else begin : g_src_lvl
      assign x = g_lvl[l-1].y;
    end

    // Select bits travel with the beat so each level sees its own sel.
    if (S == 0) begin : g_sel_in
      assign b = sel[l];
    end else begin : g_sel_reg
      assign b = g_stg[S-1].q[l];
    end

    for (genvar j = 0; j < (N >> (l + 1)); j++) begin : g_mux
      assign y[j*W +: W] = b ? x[(2*j+1)*W +: W]
                             : x[(2*j)*W +: W];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int E  = ((s + 1) * REG_EVERY > SEL_W)
                      ? SEL_W : (s + 1) * REG_EVERY;
    localparam int WD = (N >> E) * W;

    logic [WD-1:0]    d;
    logic [SEL_W-1:0] q;
    logic             v;
    logic [SEL_W-1:0] q_nxt;
    logic             v_nxt;

    if (s == 0) begin : g_first
      assign q_nxt = sel;
      assign v_nxt = in_valid & in_ready;
    end else begin : g_next
      assign q_nxt = g_stg[s-1].q;
      assign v_nxt = g_stg[s-1].v;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        d <= '0;
        q <= '0;
        v <= 1'b0;
      end else if (en) begin
        d <= g_lvl[E-1].y;
        q <= q_nxt;
        v <= v_nxt;
      end
    end
  end

  assign out_data  = g_stg[STAGES-1].d;
  assign out_sel   = g_stg[STAGES-1].q;
  assign out_valid = g_stg[STAGES-1].v;

endmodule

// File: tb/tb_mux_n_1_pipelined.sv
// Bench for mux_n_1_pipelined: table vectors, directed stall/reset
// sequences and a random handshake run against a FIFO reference model.
module tb_mux_n_1_pipelined;

  localparam int W  = 4;
  localparam int SW = 3;
  localparam int N  = 8;
  localparam int ST = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [N*W-1:0] data;
  logic [SW-1:0] sel, out_sel;
  logic [W-1:0]  out_data;

  logic          in_valid2, in_ready2, out_valid2, out_ready2;
  logic [N*W-1:0] data2;
  logic [SW-1:0] sel2, out_sel2;
  logic [W-1:0]  out_data2;

  mux_n_1_pipelined #(.W(W), .SEL_W(SW), .REG_EVERY(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
  );

  mux_n_1_pipelined #(.W(W), .SEL_W(SW), .REG_EVERY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .data(data2), .sel(sel2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_sel(out_sel2)
  );

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    int            acc;
    int            stl;
  } exp_t;

  typedef struct {
    logic [SW-1:0] s;
    logic [W-1:0]  d;
  } vec_t;

  exp_t q[$];
  vec_t tv[8];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stalls = 0;
  int n_in = 0;
  bit hold_v = 0;
  logic [W-1:0]  hold_d;
  logic [SW-1:0] hold_s;
  bit use_tbl = 0;
  logic [W-1:0] tbl_exp;
  bit pending = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_pick(logic [N*W-1:0] d,
                                            logic [SW-1:0] s);
    return d[int'(s)*W +: W];
  endfunction

  // Called just after a negedge with inputs set; ends on the next negedge.
  task automatic cycle();
    exp_t e;
    #1;
    if (!rst_n) begin
      q.delete();
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("hold_data", out_data, hold_d);
        chk("hold_sel", out_sel, hold_s);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_sel", out_sel, e.s);
          chk("latency", cyc - e.acc, ST + stalls - e.stl);
        end
      end
      if (in_valid && in_ready) begin
        e.d   = use_tbl ? tbl_exp : ref_pick(data, sel);
        e.s   = sel;
        e.acc = cyc;
        e.stl = stalls;
        q.push_back(e);
        n_in++;
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_s = out_sel;
      if (out_valid && !out_ready) stalls++;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Producer holds an offered beat until it is taken.
  task automatic step(bit want, bit rdy, int er);
    bit took;
    if (!pending && want) begin
      data    = $urandom;
      sel     = SW'($urandom);
      pending = 1;
    end
    in_valid  = pending;
    out_ready = rdy;
    #1;
    if (er >= 0) chk("in_ready", in_ready, er[0]);
    took = in_valid && in_ready;
    cycle();
    if (took) pending = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || pending) && n < 200) begin
      step(0, 1, -1);
      n++;
    end
    in_valid = 0;
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{3'd0, 4'h8};
    tv[1] = '{3'd1, 4'h9};
    tv[2] = '{3'd2, 4'hA};
    tv[3] = '{3'd3, 4'hB};
    tv[4] = '{3'd4, 4'hC};
    tv[5] = '{3'd5, 4'hD};
    tv[6] = '{3'd6, 4'hE};
    tv[7] = '{3'd7, 4'hF};

    rst_n = 0; in_valid = 0; out_ready = 0; data = '0; sel = '0;
    in_valid2 = 0; out_ready2 = 1; data2 = '0; sel2 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid2", out_valid2, 0);
    cycle();
    rst_n = 1;

    // Table sweep: chan k = k+8
    data = 32'hFEDC_BA98;
    use_tbl = 1;
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      sel = tv[i].s;
      tbl_exp = tv[i].d;
      in_valid = 1;
      cycle();
    end
    in_valid = 0;
    use_tbl = 0;
    drain();

    // Back-to-back random beats at full rate
    for (int i = 0; i < 16; i++) step(1, 1, 1);
    drain();

    // Fill, then 5 stall cycles
    for (int i = 0; i < 6; i++) step(1, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, -1);
    drain();

    // Two-stage instance: sel=5, chan5=A
    data2 = $urandom;
    data2[5*W +: W] = 4'hA;
    sel2 = 3'd5;
    in_valid2 = 1;
    #1 chk("t4_in_ready2", in_ready2, 1);
    cycle();
    in_valid2 = 0;
    #1 chk("t4_not_early", out_valid2, 0);
    cycle();
    #1;
    chk("t4_valid", out_valid2, 1);
    chk("t4_data", out_data2, 4'hA);
    chk("t4_sel", out_sel2, 3'd5);
    cycle();

    // Reset with 3 beats in flight
    for (int i = 0; i < 3; i++) step(1, 0, 1);
    rst_n = 0;
    in_valid = 1;
    out_ready = 0;
    #1 chk("t5_in_ready_rst", in_ready, 0);
    cycle();
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_out_sel", out_sel, 0);
    chk("t5_in_ready_hold", in_ready, 0);
    cycle();
    rst_n = 1;
    in_valid = 0;
    pending = 0;
    #1 chk("t5_in_ready_rel", in_ready, 1);
    cycle();

    // Random handshake run
    begin
      int guard = 0;
      int start = n_in;
      while (n_in - start < 1000 && guard < 20000) begin
        step(1'($urandom), 1'($urandom), -1);
        guard++;
      end
      chk("t6_beats", n_in - start >= 1000, 1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
